// File: rtl/memory_lsu_if.sv
// +-----------------------------------------------------------------------+
// | memory_lsu_if : data-memory req/gnt/rvalid bus between LSU and memory |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

interface memory_lsu_if #(
  parameter int ADDR_W = 32
) ();
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [3:0]        dmem_be;
  logic [31:0]       dmem_wdata;
  logic              dmem_gnt;
  logic              dmem_rvalid;
  logic [31:0]       dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/memory_lsu.sv
// +-----------------------------------------------------------------------+
// | memory_lsu : memory-stage load/store unit, one outstanding access     |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module memory_lsu #(
  parameter int ADDR_W = 32
) (
  input  wire logic              clk_i,
  input  wire logic              rst_ni,
  input  wire logic              mem_valid_mr_i,
  input  wire logic              mem_read_mr_i,
  input  wire logic              mem_write_mr_i,
  input  wire logic [2:0]        funct3_mr_i,
  input  wire logic [ADDR_W-1:0] addr_mr_i,
  input  wire logic [31:0]       write_data_mr_i,
  input  wire logic              flush_i,
  memory_lsu_if.master           dmem,
  output      logic [31:0]       load_data_mr_o,
  output      logic              misaligned_o,
  output      logic              stall_o
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2,
    DRAIN       = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [31:0] load_q;
  logic        mem_op;
  logic        access;
  logic        req;
  logic        stall;
  logic        load_done;
  logic        use_rdata;
  logic [1:0]  size;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] load_fmt;
  logic [31:0] wdata;
  logic [3:0]  be;

  assign size   = funct3_mr_i[1:0];
  assign mem_op = mem_valid_mr_i & (mem_read_mr_i | mem_write_mr_i);

  assign misaligned_o = mem_op & (((size == 2'b01) & addr_mr_i[0]) |
                                  ((size == 2'b10) & (addr_mr_i[1:0] != 2'b00)));
  assign access = mem_op & ~misaligned_o & ~flush_i;

  always_comb begin
    be    = 4'b0000;
    wdata = write_data_mr_i;
    case (size)
      2'b00: begin
        be    = 4'b0001 << addr_mr_i[1:0];
        wdata = {4{write_data_mr_i[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << {addr_mr_i[1], 1'b0};
        wdata = {2{write_data_mr_i[15:0]}};
      end
      default: be = 4'b1111;
    endcase
    if (!mem_op) be = 4'b0000;
  end

  always_comb begin
    rbyte = dmem.dmem_rdata[7:0];
    case (addr_mr_i[1:0])
      2'b01:   rbyte = dmem.dmem_rdata[15:8];
      2'b10:   rbyte = dmem.dmem_rdata[23:16];
      2'b11:   rbyte = dmem.dmem_rdata[31:24];
      default: rbyte = dmem.dmem_rdata[7:0];
    endcase
    rhalf = addr_mr_i[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    case (size)
      2'b00:   load_fmt = {{24{~funct3_mr_i[2] & rbyte[7]}}, rbyte};
      2'b01:   load_fmt = {{16{~funct3_mr_i[2] & rhalf[15]}}, rhalf};
      default: load_fmt = dmem.dmem_rdata;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      load_q <= 32'h0;
    end else begin
      state <= state_next;
      if (load_done) load_q <= load_fmt;
    end
  end

  always_comb begin
    state_next = state;
    req        = 1'b0;
    stall      = 1'b0;
    load_done  = 1'b0;
    case (state)
      // IDLE and WAIT_GNT resolve a grant identically; losing the access
      // (flush or dropped valid) while waiting for grant abandons the request.
      IDLE, WAIT_GNT: begin
        state_next = IDLE;
        if (access) begin
          req = 1'b1;
          if (dmem.dmem_gnt) begin
            if (mem_read_mr_i) begin
              if (dmem.dmem_rvalid) begin
                load_done = 1'b1;
              end else begin
                state_next = WAIT_RVALID;
                stall      = 1'b1;
              end
            end
          end else begin
            state_next = WAIT_GNT;
            stall      = 1'b1;
          end
        end
      end
      WAIT_RVALID: begin
        if (dmem.dmem_rvalid) begin
          load_done  = 1'b1;
          state_next = IDLE;
        end else if (flush_i) begin
          state_next = DRAIN;
        end else begin
          stall = 1'b1;
        end
      end
      DRAIN: begin
        // A new access waits here until the stale read response has gone by.
        stall = access;
        if (dmem.dmem_rvalid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign use_rdata = ((state == IDLE) & dmem.dmem_rvalid) | load_done;

  assign load_data_mr_o   = use_rdata ? load_fmt : load_q;
  assign stall_o          = stall & rst_ni;
  assign dmem.dmem_req    = req & rst_ni;
  assign dmem.dmem_we     = mem_write_mr_i & mem_op;
  assign dmem.dmem_addr   = {addr_mr_i[ADDR_W-1:2], 2'b00};
  assign dmem.dmem_be     = be;
  assign dmem.dmem_wdata  = wdata;

endmodule

`default_nettype wire

// File: tb/tb_memory_lsu.sv
// +-----------------------------------------------------------------------+
// | tb_memory_lsu : scoreboard bench for memory_lsu                       |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_memory_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        flush = 1'b0;
  logic [31:0] load_data;
  logic        misaligned;
  logic        stall;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  bus_t        bus_exp_q[$];
  logic [31:0] load_exp_q[$];

  memory_lsu_if #(.ADDR_W(32)) bus ();

  memory_lsu #(.ADDR_W(32)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .mem_valid_mr_i  (mem_valid),
    .mem_read_mr_i   (mem_read),
    .mem_write_mr_i  (mem_write),
    .funct3_mr_i     (funct3),
    .addr_mr_i       (addr),
    .write_data_mr_i (wdata),
    .flush_i         (flush),
    .dmem            (bus),
    .load_data_mr_o  (load_data),
    .misaligned_o    (misaligned),
    .stall_o         (stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops expected bus requests on req&gnt and load results on completion.
  always @(negedge clk) begin
    bus_t e;
    if (rst_n) begin
      if (bus.dmem_req && bus.dmem_gnt) begin
        if (bus_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got addr %h expected no request", bus.dmem_addr);
        end else begin
          e = bus_exp_q.pop_front();
          check("bus_we",    {31'h0, bus.dmem_we}, {31'h0, e.we});
          check("bus_addr",  bus.dmem_addr, e.addr);
          check("bus_be",    {28'h0, bus.dmem_be}, {28'h0, e.be});
          check("bus_wdata", bus.dmem_wdata, e.wdata);
        end
      end
      if (mem_valid && mem_read && !flush && !misaligned && !stall) begin
        if (load_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_load: got %h expected no completion", load_data);
        end else begin
          check("load_data", load_data, load_exp_q.pop_front());
        end
      end
    end
  end

  task automatic idle_inputs();
    mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; flush = 1'b0;
    funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = 32'h0;
  endtask

  // gw: cycles without grant; rw: cycles between grant and rvalid (loads).
  task automatic run_access(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input int gw, input int rw,
                            input logic [31:0] rword, input logic [3:0] ebe,
                            input logic [31:0] ewd, input logic [31:0] eload,
                            input int estall);
    int total;
    int stalls;
    total  = gw + (ld ? rw : 0);
    stalls = 0;
    bus_exp_q.push_back('{we: ~ld, addr: {a[31:2], 2'b00}, be: ebe, wdata: ewd});
    if (ld) load_exp_q.push_back(eload);
    mem_valid = 1'b1; mem_read = ld; mem_write = ~ld;
    funct3 = f3; addr = a; wdata = wd;
    for (int k = 0; k <= total; k++) begin
      bus.dmem_gnt    = (k == gw);
      bus.dmem_rvalid = ld && (k == total);
      bus.dmem_rdata  = (ld && (k == total)) ? rword : 32'h0;
      @(negedge clk);
      if (stall) stalls++;
      @(posedge clk);
      #1;
    end
    idle_inputs();
    check("stall_cycles", stalls, estall);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req",        {31'h0, bus.dmem_req}, 32'h0);
    check("rst_stall",      {31'h0, stall}, 32'h0);
    check("rst_load_data",  load_data, 32'h0);
    check("rst_misaligned", {31'h0, misaligned}, 32'h0);
    check("rst_be",         {28'h0, bus.dmem_be}, 32'h0);
    @(posedge clk);
    #1;

    // Stores: SW, SB, SH with zero-wait grant.
    run_access(1'b0, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0, 4'b1111, 32'hDEADBEEF, 32'h0, 0);
    run_access(1'b0, 3'b000, 32'h103, 32'h000000A5, 0, 0, 32'h0, 4'b1000, 32'hA5A5A5A5, 32'h0, 0);
    run_access(1'b0, 3'b001, 32'h102, 32'h00001234, 0, 0, 32'h0, 4'b1100, 32'h12341234, 32'h0, 0);

    // Loads with varied grant/response latency.
    run_access(1'b1, 3'b000, 32'h101, 32'h0, 2, 1, 32'h000080FF, 4'b0010, 32'h0, 32'hFFFFFF80, 3);
    run_access(1'b1, 3'b100, 32'h101, 32'h0, 2, 1, 32'h000080FF, 4'b0010, 32'h0, 32'h00000080, 3);
    run_access(1'b1, 3'b001, 32'h106, 32'h0, 0, 0, 32'h80010000, 4'b1100, 32'h0, 32'hFFFF8001, 0);
    run_access(1'b1, 3'b101, 32'h10A, 32'h0, 1, 0, 32'hF00D1111, 4'b1100, 32'h0, 32'h0000F00D, 1);
    run_access(1'b1, 3'b010, 32'h10C, 32'h0, 0, 2, 32'hCAFEF00D, 4'b1111, 32'h0, 32'hCAFEF00D, 2);

    // Misaligned LW and LH: no request, no stall.
    mem_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h102; bus.dmem_gnt = 1'b1;
    @(negedge clk);
    check("mis_lw_flag",  {31'h0, misaligned}, 32'h1);
    check("mis_lw_req",   {31'h0, bus.dmem_req}, 32'h0);
    check("mis_lw_stall", {31'h0, stall}, 32'h0);
    @(posedge clk);
    #1;
    funct3 = 3'b001; addr = 32'h101;
    @(negedge clk);
    check("mis_lh_flag",  {31'h0, misaligned}, 32'h1);
    check("mis_lh_req",   {31'h0, bus.dmem_req}, 32'h0);
    check("mis_lh_stall", {31'h0, stall}, 32'h0);
    @(posedge clk);
    #1;
    idle_inputs();

    // Flush while a read is outstanding, then a new load across the drain.
    bus_exp_q.push_back('{we: 1'b0, addr: 32'h200, be: 4'hF, wdata: 32'h0});
    mem_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h200; bus.dmem_gnt = 1'b1;
    @(negedge clk);
    check("flush_pre_stall", {31'h0, stall}, 32'h1);
    @(posedge clk);
    #1;
    bus.dmem_gnt = 1'b0; flush = 1'b1;
    @(negedge clk);
    check("flush_stall_drop", {31'h0, stall}, 32'h0);
    check("flush_req",        {31'h0, bus.dmem_req}, 32'h0);
    @(posedge clk);
    #1;
    flush = 1'b0; addr = 32'h300;
    @(negedge clk);
    check("drain_req",   {31'h0, bus.dmem_req}, 32'h0);
    check("drain_stall", {31'h0, stall}, 32'h1);
    @(posedge clk);
    #1;
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    check("drain_rv_req",   {31'h0, bus.dmem_req}, 32'h0);
    check("drain_rv_stall", {31'h0, stall}, 32'h1);
    @(posedge clk);
    #1;
    bus_exp_q.push_back('{we: 1'b0, addr: 32'h300, be: 4'hF, wdata: 32'h0});
    load_exp_q.push_back(32'h12345678);
    bus.dmem_gnt = 1'b1; bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h12345678;
    @(negedge clk);
    check("post_drain_stall", {31'h0, stall}, 32'h0);
    @(posedge clk);
    #1;
    idle_inputs();

    // Reset asserted while waiting for grant.
    mem_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h400;
    @(negedge clk);
    check("rst_pre_req", {31'h0, bus.dmem_req}, 32'h1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_req",   {31'h0, bus.dmem_req}, 32'h0);
    check("rst_mid_stall", {31'h0, stall}, 32'h0);
    check("rst_mid_load",  load_data, 32'h0);
    idle_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rel_stall", {31'h0, stall}, 32'h0);
    check("rst_rel_req",   {31'h0, bus.dmem_req}, 32'h0);
    @(posedge clk);
    #1;
    run_access(1'b0, 3'b010, 32'h500, 32'h0BADF00D, 0, 0, 32'h0, 4'b1111, 32'h0BADF00D, 32'h0, 0);

    repeat (2) @(posedge clk);
    check("bus_queue_empty",  bus_exp_q.size(), 32'h0);
    check("load_queue_empty", load_exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
